// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - tempo-divided step index sequencer (up/down, optional ping-pong)
// Optional feature macro: STEP_SEQ_PINGPONG_EN adds the pingpong input and bounce direction.
module step_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic        restart,
   input  logic [15:0] tempo_div,
   input  logic [2:0]  len,
   input  logic        dir,
`ifdef STEP_SEQ_PINGPONG_EN
   input  logic        pingpong,
`endif
   output logic [2:0]  s,
   output logic        step_tick,
   output logic        running
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   logic [15:0] presc;
   logic        terminal;
   logic [2:0]  start_step;
   logic [2:0]  next_step;

`ifdef STEP_SEQ_PINGPONG_EN
   logic        bounce_up;
   logic        next_bounce_up;
`endif

   // Advance decision uses the live len/dir/tempo_div, so mid-run edits apply at the next terminal count.
   always_comb begin
      terminal   = (presc >= tempo_div);
      start_step = dir ? len : 3'd0;
      if (!dir) begin
         next_step = (s >= len) ? 3'd0 : s + 3'd1;
      end else begin
         next_step = ((s == 3'd0) || (s > len)) ? len : s - 3'd1;
      end
`ifdef STEP_SEQ_PINGPONG_EN
      next_bounce_up = bounce_up;
      if (pingpong) begin
         start_step = 3'd0;
         if (len == 3'd0) begin
            next_step      = 3'd0;
            next_bounce_up = 1'b1;
         end else if (bounce_up) begin
            if (s >= len) begin
               next_step      = len - 3'd1;
               next_bounce_up = 1'b0;
            end else begin
               next_step = s + 3'd1;
            end
         end else begin
            // Turn at 0 without repeating it; an out-of-range s drops straight to len.
            if (s == 3'd0) begin
               next_step      = 3'd1;
               next_bounce_up = 1'b1;
            end else if (s > len) begin
               next_step = len;
            end else begin
               next_step = s - 3'd1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         s         <= 3'd0;
         presc     <= 16'd0;
         step_tick <= 1'b0;
         running   <= 1'b0;
`ifdef STEP_SEQ_PINGPONG_EN
         bounce_up <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               presc <= 16'd0;
               if (run) begin
                  state     <= RUN;
                  s         <= start_step;
                  step_tick <= 1'b1;
                  running   <= 1'b1;
`ifdef STEP_SEQ_PINGPONG_EN
                  bounce_up <= 1'b1;
`endif
               end else begin
                  step_tick <= 1'b0;
                  running   <= 1'b0;
               end
            end
            RUN: begin
               if (!run) begin
                  state     <= IDLE;
                  presc     <= 16'd0;
                  step_tick <= 1'b0;
                  running   <= 1'b0;
               end else if (restart) begin
                  s         <= start_step;
                  presc     <= 16'd0;
                  step_tick <= 1'b1;
`ifdef STEP_SEQ_PINGPONG_EN
                  bounce_up <= 1'b1;
`endif
               end else if (terminal) begin
                  s         <= next_step;
                  presc     <= 16'd0;
                  step_tick <= 1'b1;
`ifdef STEP_SEQ_PINGPONG_EN
                  bounce_up <= next_bounce_up;
`endif
               end else begin
                  presc     <= presc + 16'd1;
                  step_tick <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               presc     <= 16'd0;
               step_tick <= 1'b0;
               running   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer against a behavioural model
module tb_step_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        restart;
   logic [15:0] tempo_div;
   logic [2:0]  len;
   logic        dir;
   logic [2:0]  s;
   logic        step_tick;
   logic        running;
`ifdef STEP_SEQ_PINGPONG_EN
   logic        pingpong;
`endif

   int checks;
   int failures;

   // Behavioural reference: running flag, current step, tick, cycles spent in the current step.
   bit m_running;
   bit m_tick;
   int m_s;
   int m_cnt;

   step_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .restart   (restart),
      .tempo_div (tempo_div),
      .len       (len),
      .dir       (dir),
`ifdef STEP_SEQ_PINGPONG_EN
      .pingpong  (pingpong),
`endif
      .s         (s),
      .step_tick (step_tick),
      .running   (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_running = 1'b0;
      m_tick    = 1'b0;
      m_s       = 0;
      m_cnt     = 0;
   endtask

   task automatic model_edge();
      int l;
      int start;
      l     = int'(len);
      start = dir ? l : 0;
      if (!m_running) begin
         m_cnt = 0;
         if (run) begin
            m_running = 1'b1;
            m_s       = start;
            m_tick    = 1'b1;
         end else begin
            m_tick = 1'b0;
         end
      end else if (!run) begin
         m_running = 1'b0;
         m_tick    = 1'b0;
         m_cnt     = 0;
      end else if (restart) begin
         m_s    = start;
         m_cnt  = 0;
         m_tick = 1'b1;
      end else if (m_cnt >= int'(tempo_div)) begin
         if (!dir) m_s = (m_s > l) ? 0 : (m_s + 1) % (l + 1);
         else      m_s = (m_s == 0 || m_s > l) ? l : m_s - 1;
         m_cnt  = 0;
         m_tick = 1'b1;
      end else begin
         m_cnt  = m_cnt + 1;
         m_tick = 1'b0;
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1; restart = 1'b0;
      tempo_div = 16'd3; len = 3'd7; dir = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({running, step_tick, s} !== 5'b0) begin
         failures++;
         $display("FAIL reset_hold got run=%0b tick=%0b s=%0d want 0/0/0", running, step_tick, s);
      end
      rst_n = 1'b1;
      tick_cycle();
      checks++;
      if (running !== 1'b1 || step_tick !== 1'b1 || s !== 3'd0) begin
         failures++;
         $display("FAIL reset_release_first_edge got run=%0b tick=%0b s=%0d want 1/1/0", running, step_tick, s);
      end
   endtask

   task automatic test_count_up();
      run = 1'b0;
      tick_cycle();
      tempo_div = 16'd3; len = 3'd7; dir = 1'b0; run = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick_cycle();
         checks++;
         if (s !== 3'((i / 4) % 8) || step_tick !== (i % 4 == 0) || running !== 1'b1) begin
            failures++;
            $display("FAIL count_up i=%0d got s=%0d tick=%0b run=%0b want s=%0d tick=%0b run=1",
                     i, s, step_tick, running, (i / 4) % 8, (i % 4 == 0));
         end
      end
   endtask

   task automatic test_down_fast();
      run = 1'b0;
      tick_cycle();
      tempo_div = 16'd0; len = 3'd2; dir = 1'b1; run = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick_cycle();
         checks++;
         if (s !== 3'(2 - (i % 3)) || step_tick !== 1'b1) begin
            failures++;
            $display("FAIL down_fast i=%0d got s=%0d tick=%0b want s=%0d tick=1", i, s, step_tick, 2 - (i % 3));
         end
      end
   endtask

   task automatic test_len_change();
      for (int d = 0; d < 2; d++) begin
         int k;
         int want;
         run = 1'b0;
         tick_cycle();
         tempo_div = 16'd1; len = 3'd7; dir = d[0]; run = 1'b1;
         k = 0;
         do begin
            tick_cycle();
            k++;
         end while (!(m_s == 5 && m_tick) && k < 100);
         checks++;
         if (k >= 100 || s !== 3'd5) begin
            failures++;
            $display("FAIL len_change_reach5 dir=%0d got s=%0d want 5", d, s);
         end
         len  = 3'd3;
         want = d ? 3 : 0;
         k    = 0;
         do begin
            tick_cycle();
            k++;
         end while (!step_tick && k < 10);
         checks++;
         if (s !== 3'(want) || step_tick !== 1'b1) begin
            failures++;
            $display("FAIL len_change dir=%0d got s=%0d tick=%0b want s=%0d tick=1", d, s, step_tick, want);
         end
      end
   endtask

   task automatic test_restart();
      int k;
      run = 1'b0;
      tick_cycle();
      tempo_div = 16'd3; len = 3'd7; dir = 1'b0; run = 1'b1;
      k = 0;
      do begin
         tick_cycle();
         k++;
      end while (!(m_running && m_s == 4 && m_cnt >= int'(tempo_div)) && k < 200);
      checks++;
      if (k >= 200 || s !== 3'd4) begin
         failures++;
         $display("FAIL restart_reach_terminal got s=%0d want 4", s);
      end
      restart = 1'b1;
      tick_cycle();
      restart = 1'b0;
      checks++;
      if (s !== 3'd0 || step_tick !== 1'b1) begin
         failures++;
         $display("FAIL restart_load got s=%0d tick=%0b want s=0 tick=1", s, step_tick);
      end
      for (int i = 1; i <= 4; i++) begin
         tick_cycle();
         checks++;
         if (s !== ((i == 4) ? 3'd1 : 3'd0) || step_tick !== (i == 4)) begin
            failures++;
            $display("FAIL restart_after i=%0d got s=%0d tick=%0b want s=%0d tick=%0b",
                     i, s, step_tick, (i == 4), (i == 4));
         end
      end
   endtask

   task automatic test_stop_and_async_reset();
      int k;
      run = 1'b0;
      tick_cycle();
      tempo_div = 16'd2; len = 3'd7; dir = 1'b0; run = 1'b1;
      k = 0;
      do begin
         tick_cycle();
         k++;
      end while (!(m_s == 6 && m_tick) && k < 100);
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick_cycle();
         checks++;
         if (running !== 1'b0 || s !== 3'd6 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL stop_hold i=%0d got run=%0b s=%0d tick=%0b want 0/6/0", i, running, s, step_tick);
         end
      end
      run = 1'b1;
      tick_cycle();
      checks++;
      if (running !== 1'b1 || s !== 3'd0 || step_tick !== 1'b1) begin
         failures++;
         $display("FAIL stop_relaunch got run=%0b s=%0d tick=%0b want 1/0/1", running, s, step_tick);
      end
      repeat (7) tick_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (running !== 1'b0 || s !== 3'd0 || step_tick !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got run=%0b s=%0d tick=%0b want 0/0/0", running, s, step_tick);
      end
      model_reset();
      tick_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(39, 0) == 0) run = ~run;
         restart = ($urandom_range(15, 0) == 0);
         if ($urandom_range(29, 0) == 0) len = 3'($urandom_range(7, 0));
         if ($urandom_range(29, 0) == 0) dir = ~dir;
         if ($urandom_range(49, 0) == 0) tempo_div = 16'($urandom_range(4, 0));
         tick_cycle();
         checks++;
         if ({running, step_tick, s} !== {m_running, m_tick, 3'(m_s)}) begin
            failures++;
            $display("FAIL random i=%0d got run=%0b tick=%0b s=%0d want run=%0b tick=%0b s=%0d",
                     i, running, step_tick, s, m_running, m_tick, m_s);
         end
      end
      restart = 1'b0;
   endtask

`ifdef STEP_SEQ_PINGPONG_EN
   task automatic test_pingpong();
      int exp_seq [10];
      exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
      run = 1'b0;
      tick_cycle();
      pingpong = 1'b1; tempo_div = 16'd0; len = 3'd3; dir = 1'b1; run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick_cycle();
         checks++;
         if (s !== 3'(exp_seq[i]) || step_tick !== 1'b1) begin
            failures++;
            $display("FAIL pingpong i=%0d got s=%0d tick=%0b want s=%0d tick=1", i, s, step_tick, exp_seq[i]);
         end
      end
      pingpong = 1'b0;
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
`ifdef STEP_SEQ_PINGPONG_EN
      pingpong = 1'b0;
`endif
      test_reset();
      test_count_up();
      test_down_fast();
      test_len_change();
      test_restart();
      test_stop_and_async_reset();
      test_random();
`ifdef STEP_SEQ_PINGPONG_EN
      test_pingpong();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
